// File: rtl/asg_pkg.sv
// Shared widths and types for the ASG keystream byte packer.
package asg_pkg;

   localparam int unsigned BYTE_W     = 8;
   localparam int unsigned FIFO_DEPTH = 2;
   localparam int unsigned CNT_W      = $clog2(BYTE_W);
   localparam int unsigned FILL_W     = $clog2(FIFO_DEPTH + 1);

   typedef logic [BYTE_W-1:0] byte_t;

   // Von Neumann pair tracker: waiting for first bit of a pair, or holding it.
   typedef enum logic {
      IDLE       = 1'b0,
      HAVE_FIRST = 1'b1
   } vn_state_t;

endpackage

// File: rtl/asg_vn_debias.sv
// Von Neumann debias stage: 01 -> 0, 10 -> 1, 00/11 dropped; one registered bit per cycle.
// Instantiated by asg_byte_packer only when ASG_VN_DEBIAS_EN is defined.
module asg_vn_debias
   import asg_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic ena,
   input  logic bit_in,
   input  logic bit_valid,
   output logic bit_out,
   output logic bit_out_valid
);

   vn_state_t r_state;
   logic      r_first;
   logic      r_bit_out;
   logic      r_bit_out_valid;

   // With ena low everything holds, so a pending output bit survives until the packer can take it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state         <= IDLE;
         r_first         <= 1'b0;
         r_bit_out       <= 1'b0;
         r_bit_out_valid <= 1'b0;
      end else if (ena) begin
         r_bit_out_valid <= 1'b0;
         if (bit_valid) begin
            case (r_state)
               IDLE: begin
                  r_first <= bit_in;
                  r_state <= HAVE_FIRST;
               end
               HAVE_FIRST: begin
                  r_state <= IDLE;
                  if (r_first != bit_in) begin
                     r_bit_out       <= r_first;
                     r_bit_out_valid <= 1'b1;
                  end
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   assign bit_out       = r_bit_out;
   assign bit_out_valid = r_bit_out_valid;

endmodule

// File: rtl/asg_byte_packer.sv
// Packs ASG keystream bits MSB-first into bytes and queues them in a 2-entry output FIFO.
// Define ASG_VN_DEBIAS_EN to insert the von Neumann debias stage ahead of the packer.
module asg_byte_packer
   import asg_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic              bit_in,
   input  logic              bit_valid,
   output logic [BYTE_W-1:0] byte_out,
   output logic              byte_valid,
   input  logic              byte_ready,
   output logic              overflow,
   output logic [FILL_W-1:0] fill
);

   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(BYTE_W - 1);
   localparam logic [FILL_W-1:0] FILL_ZERO = FILL_W'(0);
   localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(FIFO_DEPTH);

   logic  w_bit;
   logic  w_bit_valid;
   logic  w_accept;
   logic  w_push;
   logic  w_pop;
   byte_t w_byte;

   byte_t             r_shreg;
   logic [CNT_W-1:0]  r_cnt;
   byte_t             r_head;
   byte_t             r_tail;
   logic [FILL_W-1:0] r_fill;
   logic              r_valid;
   logic              r_overflow;

`ifdef ASG_VN_DEBIAS_EN
   asg_vn_debias u_vn_debias (
      .clk           (clk),
      .rst_n         (rst_n),
      .ena           (ena),
      .bit_in        (bit_in),
      .bit_valid     (bit_valid),
      .bit_out       (w_bit),
      .bit_out_valid (w_bit_valid)
   );
`else
   assign w_bit       = bit_in;
   assign w_bit_valid = bit_valid;
`endif

   assign w_accept = ena && w_bit_valid;
   assign w_push   = w_accept && (r_cnt == CNT_LAST);
   assign w_pop    = r_valid && byte_ready;
   assign w_byte   = {r_shreg[BYTE_W-2:0], w_bit};

   // Shift register and bit counter; the counter wraps on the byte-completing bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shreg <= '0;
         r_cnt   <= '0;
      end else if (w_accept) begin
         r_shreg <= w_byte;
         r_cnt   <= r_cnt + CNT_W'(1);
      end
   end

   // Two-entry FIFO with registered head; an empty FIFO always presents 8'h00.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_head     <= '0;
         r_tail     <= '0;
         r_fill     <= FILL_ZERO;
         r_valid    <= 1'b0;
         r_overflow <= 1'b0;
      end else if (w_push && w_pop) begin
         if (r_fill == FILL_FULL) begin
            r_head <= r_tail;
            r_tail <= w_byte;
         end else begin
            r_head <= w_byte;
         end
      end else if (w_push) begin
         if (r_fill == FILL_ZERO) begin
            r_head  <= w_byte;
            r_fill  <= FILL_ONE;
            r_valid <= 1'b1;
         end else if (r_fill == FILL_ONE) begin
            r_tail <= w_byte;
            r_fill <= FILL_FULL;
         end else begin
            r_overflow <= 1'b1;
         end
      end else if (w_pop) begin
         if (r_fill == FILL_FULL) begin
            r_head <= r_tail;
            r_tail <= '0;
            r_fill <= FILL_ONE;
         end else begin
            r_head  <= '0;
            r_fill  <= FILL_ZERO;
            r_valid <= 1'b0;
         end
      end
   end

   assign byte_out   = r_head;
   assign byte_valid = r_valid;
   assign overflow   = r_overflow;
   assign fill       = r_fill;

endmodule

// File: doc/asg_byte_packer.md
ASG_BYTE_PACKER -- requirements
Module: asg_byte_packer

Interface
REQ-001 clk  input  1  system clock; all state changes on its rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 ena  input  1  block enable; when low, input bits are ignored and the packer state holds.
REQ-004 bit_in  input  1  keystream bit from the upstream ASG generator.
REQ-005 bit_valid  input  1  bit_in is valid this cycle; there is no backpressure toward the ASG.
REQ-006 byte_out  output  8  packed byte at the FIFO head.
REQ-007 byte_valid  output  1  FIFO is non-empty and byte_out is valid.
REQ-008 byte_ready  input  1  consumer accepts byte_out when byte_valid && byte_ready.
REQ-009 overflow  output  1  sticky flag: a completed byte was dropped because the FIFO was full.
REQ-010 fill  output  2  FIFO occupancy, 0..2.

Function
REQ-011 The block SHALL accept a bit when ena && bit_valid (after the optional debias stage), shifting MSB-first: shreg <= {shreg[6:0], bit}.
REQ-012 A 3-bit counter SHALL count accepted bits; on the 8th bit it SHALL wrap to 0 and push {shreg[6:0], bit} into the FIFO in the same edge.
REQ-013 The output FIFO SHALL be 2 entries deep, first-in first-out, with registered head; byte_valid SHALL rise on the clock edge that performs the push into an empty FIFO (1-cycle latency from the 8th bit).
REQ-014 A pop SHALL occur on an edge where byte_valid && byte_ready; byte_out SHALL be stable while byte_valid && !byte_ready.
REQ-015 Simultaneous push and pop SHALL both succeed at any fill, including fill=2; fill is unchanged.
REQ-016 A push at fill=2 without a pop SHALL drop the byte, set overflow, and leave FIFO contents unchanged; the bit counter still wraps.
REQ-017 overflow SHALL remain set until reset.
REQ-018 When ena=0, shreg, the counter and the debias state SHALL hold; FIFO pops SHALL still proceed.
REQ-019 byte_out SHALL read 8'h00 when fill=0.

Reset
REQ-020 While rst_n=0, shreg=0, counter=0, fill=0, byte_valid=0, byte_out=8'h00, overflow=0, and debias state=IDLE, all asynchronously.
REQ-021 Reset asserted mid-byte SHALL discard partial bits; the first bit after release starts a new byte.
REQ-022 Reset release is synchronous to clk; the first bit can be accepted on the first edge with rst_n=1.

Configuration
REQ-023 With macro ASG_VN_DEBIAS_EN defined, a von Neumann stage SHALL sit before the packer: IDLE captures the first bit -> HAVE_FIRST; the second bit returns to IDLE; pair 01 emits 0, pair 10 emits 1, and pairs 00 and 11 emit nothing.
REQ-024 Without ASG_VN_DEBIAS_EN, every ena && bit_valid bit SHALL go directly to the packer; no debias logic is present.
REQ-025 The debias stage SHALL emit at most one bit per cycle, registered, adding 1 cycle of latency.

Structure
REQ-026 Package asg_pkg SHALL hold BYTE_W=8, FIFO_DEPTH=2, and the debias state enum {IDLE, HAVE_FIRST}.
REQ-027 The debias logic SHALL be sub-module asg_vn_debias (clk, rst_n, ena, bit_in, bit_valid -> bit_out, bit_out_valid), instantiated only under ASG_VN_DEBIAS_EN.

Verification
REQ-028 No debias: bits 1,0,1,0,0,1,0,1 on consecutive cycles with byte_ready=1 -> byte_out=8'hA5 and byte_valid high for 1 cycle, starting the edge after the 8th bit.
REQ-029 byte_ready=0, 24 bits forming 8'h11, 8'h22, 8'h33 -> fill=2, overflow=1; then byte_ready=1 -> outputs 8'h11 then 8'h22; 8'h33 is never output.
REQ-030 fill=2, 8th bit arrives on the same edge as a pop -> no overflow, fill stays 2, order preserved.
REQ-031 After 5 bits, pulse rst_n low -> all outputs are at reset values immediately; the next 8 bits (8'hFF) -> byte_out=8'hFF.
REQ-032 ena=0 for 10 cycles mid-byte while bit_valid=1 -> counter holds, and the byte completes correctly when ena returns.
REQ-033 ASG_VN_DEBIAS_EN: pairs 01,10,00,11,10,01,10,10,01,10 -> packed bits 0,1,1,0,1,1,0,1 -> byte_out=8'h6D.
